// File: rtl/itlb_ptw.sv
// rtl/itlb_ptw.sv - Sv32 page-table walker serving ITLB misses
module itlb_ptw #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int ASID_WD  = 9
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                flush_i,
  input  logic [21:0]         satp_ppn_i,
  input  logic [ASID_WD-1:0]  satp_asid_i,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [VADDR_WD-1:0] miss_vaddr_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [PADDR_WD-1:0] mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [31:0]         mem_rsp_data_i,
  input  logic                mem_rsp_err_i,
  output logic                refill_valid_o,
  output logic [19:0]         refill_vpn_o,
  output logic [21:0]         refill_ppn_o,
  output logic                refill_super_o,
  output logic [7:0]          refill_flags_o,
  output logic [ASID_WD-1:0]  refill_asid_o,
  output logic                page_fault_o,
  output logic                access_except_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    RESP    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    EV_NEXT   = 2'd0,
    EV_REFILL = 2'd1,
    EV_FAULT  = 2'd2,
    EV_ACCESS = 2'd3
  } ev_t;

  state_t              state_q;
  logic [19:0]         vpn_q;
  logic [ASID_WD-1:0]  asid_q;
  logic [21:0]         pte_ppn_q;
  logic [7:0]          pte_flags_q;
  logic                super_q;
  logic [PADDR_WD-1:0] addr_q;
  logic                req_q;
  logic                ready_q;
  logic                refill_q;
  logic                fault_q;
  logic                access_q;
  ev_t                 ev;

  logic pte_v, pte_r, pte_w, pte_x, pte_a;
  logic unused_bits;

  assign pte_v = mem_rsp_data_i[0];
  assign pte_r = mem_rsp_data_i[1];
  assign pte_w = mem_rsp_data_i[2];
  assign pte_x = mem_rsp_data_i[3];
  assign pte_a = mem_rsp_data_i[6];

  // Page offset and the RSW field never influence the walk
  assign unused_bits = ^{miss_vaddr_i[11:0], mem_rsp_data_i[9:8]};

  // Classify the arriving PTE for the level currently being walked
  always_comb begin
    ev = EV_FAULT;
    if (mem_rsp_err_i) begin
      ev = EV_ACCESS;
    end else if (!pte_v || (!pte_r && pte_w)) begin
      ev = EV_FAULT;
    end else if (pte_r || pte_x) begin
      // A megapage must have ppn0 clear; fetch needs X and an already-set A bit
      if ((state_q == L1_WAIT) && (mem_rsp_data_i[19:10] != 10'd0)) begin
        ev = EV_FAULT;
      end else if (!pte_x || !pte_a) begin
        ev = EV_FAULT;
      end else begin
        ev = EV_REFILL;
      end
    end else if (state_q == L1_WAIT) begin
      ev = EV_NEXT;
    end else begin
      ev = EV_FAULT;
    end
  end

  // Walk sequencing, request/response handshakes and registered result pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      vpn_q       <= '0;
      asid_q      <= '0;
      pte_ppn_q   <= '0;
      pte_flags_q <= '0;
      super_q     <= 1'b0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      ready_q     <= 1'b1;
      refill_q    <= 1'b0;
      fault_q     <= 1'b0;
      access_q    <= 1'b0;
    end else begin
      refill_q <= 1'b0;
      fault_q  <= 1'b0;
      access_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i && !flush_i) begin
            vpn_q   <= miss_vaddr_i[31:12];
            asid_q  <= satp_asid_i;
            addr_q  <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
            req_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (flush_i) begin
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (mem_req_ready_i) begin
            req_q   <= 1'b0;
            state_q <= (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (flush_i) begin
            // A response arriving with the flush is consumed here; otherwise drain it
            if (mem_rsp_valid_i) begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (mem_rsp_valid_i) begin
            pte_ppn_q   <= mem_rsp_data_i[31:10];
            pte_flags_q <= mem_rsp_data_i[7:0];
            super_q     <= (state_q == L1_WAIT);
            case (ev)
              EV_NEXT: begin
                addr_q  <= {mem_rsp_data_i[31:10], vpn_q[9:0], 2'b00};
                req_q   <= 1'b1;
                state_q <= L0_REQ;
              end
              EV_REFILL: begin
                refill_q <= 1'b1;
                state_q  <= RESP;
              end
              EV_FAULT: begin
                fault_q <= 1'b1;
                state_q <= RESP;
              end
              default: begin
                access_q <= 1'b1;
                state_q  <= RESP;
              end
            endcase
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        DRAIN: begin
          if (mem_rsp_valid_i) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush in the request or result cycle must leave nothing visible on the ports
  assign miss_ready_o    = ready_q;
  assign mem_req_valid_o = req_q & ~flush_i;
  assign mem_req_addr_o  = addr_q;
  assign refill_valid_o  = refill_q & ~flush_i;
  assign page_fault_o    = fault_q & ~flush_i;
  assign access_except_o = access_q & ~flush_i;

  // Megapage PPN takes its low half from the walked vaddr
  assign refill_vpn_o   = vpn_q;
  assign refill_ppn_o   = super_q ? {pte_ppn_q[21:10], vpn_q[9:0]} : pte_ppn_q;
  assign refill_super_o = super_q;
  assign refill_flags_o = pte_flags_q;
  assign refill_asid_o  = asid_q;

endmodule

// File: tb/tb_itlb_ptw.sv
// tb/tb_itlb_ptw.sv - directed scoreboard bench for itlb_ptw
module tb_itlb_ptw;

  localparam logic [21:0] SATP     = 22'h00010;
  localparam logic [1:0]  K_REFILL = 2'd1;
  localparam logic [1:0]  K_FAULT  = 2'd2;
  localparam logic [1:0]  K_ACCESS = 2'd3;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [21:0] satp_ppn_i = SATP;
  logic [8:0]  satp_asid_i = '0;
  logic        miss_valid_i = 1'b0;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b1;
  logic [33:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        refill_valid_o;
  logic [19:0] refill_vpn_o;
  logic [21:0] refill_ppn_o;
  logic        refill_super_o;
  logic [7:0]  refill_flags_o;
  logic [8:0]  refill_asid_o;
  logic        page_fault_o;
  logic        access_except_o;

  always #5 clk_i = ~clk_i;

  itlb_ptw #(.VADDR_WD(32), .PADDR_WD(34), .ASID_WD(9)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .satp_ppn_i(satp_ppn_i), .satp_asid_i(satp_asid_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_vaddr_i(miss_vaddr_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
    .refill_valid_o(refill_valid_o), .refill_vpn_o(refill_vpn_o), .refill_ppn_o(refill_ppn_o),
    .refill_super_o(refill_super_o), .refill_flags_o(refill_flags_o), .refill_asid_o(refill_asid_o),
    .page_fault_o(page_fault_o), .access_except_o(access_except_o)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic        sup;
    logic [7:0]  flags;
    logic [8:0]  asid;
  } res_t;

  res_t exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_req = 0;
  int acc_cyc = 0;
  int pulse_cyc = 0;

  // Cycle counter and accepted-request counter
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rstn_i && mem_req_valid_o && mem_req_ready_i) n_req <= n_req + 1;
  end

  // Result monitor: every pulse pops one expectation from the scoreboard
  always @(negedge clk_i) begin
    if (rstn_i && (refill_valid_o || page_fault_o || access_except_o)) begin
      res_t o_r;
      res_t e_r;
      o_r = '0;
      case ({refill_valid_o, page_fault_o, access_except_o})
        3'b100:  o_r.kind = K_REFILL;
        3'b010:  o_r.kind = K_FAULT;
        3'b001:  o_r.kind = K_ACCESS;
        default: o_r.kind = 2'd0;
      endcase
      if (o_r.kind == K_REFILL) begin
        o_r.vpn   = refill_vpn_o;
        o_r.ppn   = refill_ppn_o;
        o_r.sup   = refill_super_o;
        o_r.flags = refill_flags_o;
        o_r.asid  = refill_asid_o;
      end
      pulse_cyc = cyc;
      e_r = '0;
      if (exp_q.size() != 0) e_r = exp_q.pop_front();
      n_vec++;
      assert (o_r === e_r) else begin
        n_fail++;
        $error("FAIL result obs=%h exp=%h", o_r, e_r);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic send_miss(input logic [31:0] va, input logic [8:0] asid);
    check("miss_ready_idle", 64'(miss_ready_o), 64'd1);
    miss_valid_i = 1'b1;
    miss_vaddr_i = va;
    satp_asid_i  = asid;
    satp_ppn_i   = SATP;
    acc_cyc      = cyc;
    @(posedge clk_i); #1;
    miss_valid_i = 1'b0;
    miss_vaddr_i = $urandom;
    satp_asid_i  = 9'($urandom);
    satp_ppn_i   = 22'($urandom);
  endtask

  task automatic wait_req(input string tag, input logic [33:0] addr);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!mem_req_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_valid"}, 64'(mem_req_valid_o), 64'd1);
    check(tag, 64'(mem_req_addr_o), 64'(addr));
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    mem_rsp_err_i   = e;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
    mem_rsp_data_i  = $urandom;
  endtask

  task automatic do_walk(input string tag, input logic [31:0] va, input logic [8:0] asid,
                         input logic [31:0] pte1, input bit two, input logic [31:0] pte0,
                         input logic err0, input logic [1:0] kind, input int stall, input int lat);
    res_t e;
    int r0;
    int n;
    logic [33:0] a1;
    logic [33:0] a0;
    a1 = {SATP, va[31:22], 2'b00};
    a0 = {pte1[31:10], va[21:12], 2'b00};
    e = '0;
    e.kind = kind;
    if (kind == K_REFILL) begin
      e.vpn   = va[31:12];
      e.sup   = !two;
      e.asid  = asid;
      e.flags = two ? pte0[7:0] : pte1[7:0];
      e.ppn   = two ? pte0[31:10] : {pte1[31:20], va[21:12]};
    end
    r0 = n_req;
    mem_req_ready_i = (stall == 0);
    exp_q.push_back(e);
    send_miss(va, asid);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      check({tag, "_stall_valid"}, 64'(mem_req_valid_o), 64'd1);
      check({tag, "_stall_addr"}, 64'(mem_req_addr_o), 64'(a1));
      @(posedge clk_i); #1;
    end
    mem_req_ready_i = 1'b1;
    wait_req({tag, "_l1_addr"}, a1);
    respond(pte1, 1'b0);
    if (two) begin
      wait_req({tag, "_l0_addr"}, a0);
      respond(pte0, err0);
    end
    n = 0;
    do begin
      @(negedge clk_i); #1;
      n++;
    end while (exp_q.size() != 0 && n < 20);
    check({tag, "_pulse_seen"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({tag, "_busy_in_resp"}, 64'(miss_ready_o), 64'd0);
    if (lat >= 0) check({tag, "_latency"}, 64'(pulse_cyc - acc_cyc), 64'(lat));
    check({tag, "_req_count"}, 64'(n_req - r0), two ? 64'd2 : 64'd1);
    @(negedge clk_i);
    check({tag, "_ready_after"}, 64'(miss_ready_o), 64'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r0;
    // Reset state
    @(negedge clk_i);
    check("rst_miss_ready", 64'(miss_ready_o), 64'd1);
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr_o), 64'd0);
    check("rst_pulses", 64'({refill_valid_o, page_fault_o, access_except_o}), 64'd0);
    check("rst_refill_fields", 64'({refill_vpn_o, refill_ppn_o, refill_super_o}), 64'd0);
    check("rst_refill_meta", 64'({refill_flags_o, refill_asid_o}), 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Directed walks
    do_walk("page4k", 32'h0040_1ABC, 9'h011, 32'h0000_8001, 1'b1, 32'h0012_34CB, 1'b0, K_REFILL, 0, 5);
    do_walk("mega", 32'h1234_5678, 9'h0A5, 32'h2000_00CB, 1'b0, 32'h0, 1'b0, K_REFILL, 0, 3);
    do_walk("mega_misal", 32'h0040_1ABC, 9'h011, 32'h2000_04CB, 1'b0, 32'h0, 1'b0, K_FAULT, 0, 3);
    do_walk("l1_invalid", 32'h0040_1ABC, 9'h011, 32'h0000_00CA, 1'b0, 32'h0, 1'b0, K_FAULT, 0, 3);
    do_walk("l1_w_only", 32'h8765_4321, 9'h1FF, 32'h0000_0005, 1'b0, 32'h0, 1'b0, K_FAULT, 0, 3);
    do_walk("l0_no_x", 32'h0040_1ABC, 9'h011, 32'h0000_8001, 1'b1, 32'h0012_34C3, 1'b0, K_FAULT, 0, 5);
    do_walk("l0_no_a", 32'h0040_1ABC, 9'h011, 32'h0000_8001, 1'b1, 32'h0012_348B, 1'b0, K_FAULT, 0, 5);
    do_walk("l0_ptr", 32'h0040_1ABC, 9'h011, 32'h0000_8001, 1'b1, 32'h0012_3401, 1'b0, K_FAULT, 0, 5);
    do_walk("l0_buserr", 32'h0040_1ABC, 9'h011, 32'h0000_8001, 1'b1, 32'h0012_34CB, 1'b1, K_ACCESS, 0, 5);
    do_walk("stall", 32'hFFC0_3000, 9'h100, 32'h3FF0_00CB, 1'b0, 32'h0, 1'b0, K_REFILL, 5, -1);

    // Flush while the L0 response is outstanding; late response is drained silently
    r0 = n_req;
    send_miss(32'h0040_1ABC, 9'h022);
    wait_req("fl_l1_addr", {SATP, 10'h001, 2'b00});
    respond(32'h0000_8001, 1'b0);
    wait_req("fl_l0_addr", {22'h000020, 10'h001, 2'b00});
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("fl_drain_busy", 64'(miss_ready_o), 64'd0);
      @(posedge clk_i); #1;
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0012_34CB;
    @(negedge clk_i);
    check("fl_drain_rsp_busy", 64'(miss_ready_o), 64'd0);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check("fl_drained_ready", 64'(miss_ready_o), 64'd1);
    check("fl_req_count", 64'(n_req - r0), 64'd2);
    @(posedge clk_i); #1;

    // Flush in L1_REQ drops the request even with memory ready
    r0 = n_req;
    mem_req_ready_i = 1'b0;
    send_miss(32'h0040_1ABC, 9'h033);
    @(negedge clk_i);
    check("flreq_valid_before", 64'(mem_req_valid_o), 64'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    check("flreq_valid_dropped", 64'(mem_req_valid_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flreq_idle_ready", 64'(miss_ready_o), 64'd1);
    check("flreq_no_req", 64'(n_req - r0), 64'd0);
    @(posedge clk_i); #1;

    // Flush and miss together in IDLE: miss ignored; stray response ignored
    flush_i = 1'b1;
    miss_valid_i = 1'b1;
    miss_vaddr_i = 32'h0040_1ABC;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    miss_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 32'h2000_00CB;
    @(negedge clk_i);
    check("flmiss_ready", 64'(miss_ready_o), 64'd1);
    check("flmiss_no_req", 64'(mem_req_valid_o), 64'd0);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check("stray_rsp_idle", 64'(miss_ready_o), 64'd1);
    @(posedge clk_i); #1;

    // Asynchronous reset mid-walk returns to IDLE without waiting for a clock
    send_miss(32'h0040_1ABC, 9'h044);
    wait_req("arst_l1_addr", {SATP, 10'h001, 2'b00});
    @(posedge clk_i); #2;
    rstn_i = 1'b0;
    #1;
    check("arst_ready", 64'(miss_ready_o), 64'd1);
    check("arst_req_valid", 64'(mem_req_valid_o), 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    do_walk("after_rst", 32'h0040_1ABC, 9'h055, 32'h0000_8001, 1'b1, 32'h0012_34CB, 1'b0, K_REFILL, 0, 5);

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
